ring_buffer_ctrl: RTL and testbench

Parametrised circular register buffer driven from board push-buttons and switches. It stores up to DEPTH words of WIDTH bits and exposes the word under a single read/write pointer. The pointer moves forward on load or increment and backward on decrement. It adds per-entry valid tracking, occupancy count, full/empty/overwrite flags and a synchronous clear. It sits between the raw DE0 switch/button inputs and the seven-segment/LED display logic.

---
 rtl/ring_buffer_pkg.sv | 24 ++
 rtl/btn_cond.sv | 63 ++++++
 rtl/stavka_a.sv | 22 ++
 rtl/stavka_b.sv | 32 +++
 rtl/ring_buffer_ctrl.sv | 105 ++++++++++
 tb/tb_ring_buffer_ctrl.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ring_buffer_pkg.sv
// Shared types and pointer arithmetic for the ring buffer controller and its input conditioning.
package ring_buffer_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_LD,
        OP_INC,
        OP_DEC
    } op_t;

    // Cycles a debounced button must hold a new level before it is accepted.
    localparam int unsigned DB_CYCLES = 8;

    // Pointer arithmetic that wraps at an arbitrary depth, not just powers of two.
    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
        return (p >= depth - 32'd1) ? 32'd0 : p + 32'd1;
    endfunction

    function automatic int unsigned wrap_dec(input int unsigned p, input int unsigned depth);
        return (p == 32'd0) ? depth - 32'd1 : p - 32'd1;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw button/switch conditioning: synchroniser, optional debouncer, rising-edge pulse.
module btn_cond
    import ring_buffer_pkg::*;
#(
    parameter bit          DEBOUNCE  = 1'b0,
    parameter int unsigned DB_LENGTH = DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse
);

    logic       r_meta;
    logic       r_sync;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       w_level;

    // Pulses are suppressed until the input has been seen low once after reset,
    // so a button held through reset release needs a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            if (r_fill == 2'd2 && !r_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    generate
        if (DEBOUNCE) begin : g_db
            stavka_b #(
                .CNT_MAX(DB_LENGTH)
            ) u_db (
                .clk  (clk),
                .rst_n(rst_n),
                .i_sig(r_sync),
                .o_sig(w_level)
            );
        end else begin : g_nodb
            assign w_level = r_sync;
        end
    endgenerate

    stavka_a u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (w_level),
        .i_en   (r_armed),
        .o_pulse(o_pulse)
    );

endmodule

// File: rtl/stavka_a.sv
// Rising-edge pulse generator: one-cycle pulse per low-to-high transition of a registered level.
module stavka_a (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    input  logic i_en,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_pulse = i_sig & ~r_prev & i_en;

endmodule

// File: rtl/stavka_b.sv
// Level debouncer: the output follows the input only after it has been stable for CNT_MAX cycles.
module stavka_b #(
    parameter int unsigned CNT_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_sig
);

    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    logic [CW-1:0] r_cnt;
    logic          r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else if (i_sig == r_state) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(CNT_MAX - 1)) begin
            r_state <= i_sig;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_sig = r_state;

endmodule

// File: rtl/ring_buffer_ctrl.sv
// Circular register buffer with a single read/write pointer, valid tracking,
// occupancy count and sticky overwrite flag, driven from raw board buttons.
module ring_buffer_ctrl
    import ring_buffer_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic [PTR_W-1:0] ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    logic w_ld_p;
    logic w_clr_p;
    logic w_inc_p;
    logic w_dec_p;
    op_t  w_op;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [PTR_W-1:0] w_ptr_fwd;
    logic [PTR_W-1:0] w_ptr_bwd;

    btn_cond #(.DEBOUNCE(1'b1)) u_ld  (.clk(clk), .rst_n(rst_n), .i_raw(ld),  .o_pulse(w_ld_p));
    btn_cond #(.DEBOUNCE(1'b1)) u_clr (.clk(clk), .rst_n(rst_n), .i_raw(clr), .o_pulse(w_clr_p));
    btn_cond #(.DEBOUNCE(1'b0)) u_inc (.clk(clk), .rst_n(rst_n), .i_raw(inc), .o_pulse(w_inc_p));
    btn_cond #(.DEBOUNCE(1'b0)) u_dec (.clk(clk), .rst_n(rst_n), .i_raw(dec), .o_pulse(w_dec_p));

    // Opposing inc/dec in the same cycle cancel; a load swallows any pointer move.
    always_comb begin
        w_op = OP_NONE;
        if (w_clr_p) begin
            w_op = OP_CLR;
        end else if (w_ld_p) begin
            w_op = OP_LD;
        end else if (w_inc_p && !w_dec_p) begin
            w_op = OP_INC;
        end else if (w_dec_p && !w_inc_p) begin
            w_op = OP_DEC;
        end
    end

    assign w_ptr_fwd = PTR_W'(wrap_inc(32'(r_ptr), DEPTH));
    assign w_ptr_bwd = PTR_W'(wrap_dec(32'(r_ptr), DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '{default: '0};
            r_valid <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (w_op)
                OP_CLR: begin
                    r_mem   <= '{default: '0};
                    r_valid <= '0;
                    r_ptr   <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end
                OP_LD: begin
                    r_mem[r_ptr]   <= data_in;
                    r_valid[r_ptr] <= 1'b1;
                    r_ptr          <= w_ptr_fwd;
                    if (!r_valid[r_ptr]) begin
                        r_count <= r_count + CNT_W'(1);
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
                OP_INC:  r_ptr <= w_ptr_fwd;
                OP_DEC:  r_ptr <= w_ptr_bwd;
                default: ;
            endcase
        end
    end

    assign data_out  = r_mem[r_ptr];
    assign out_valid = r_valid[r_ptr];
    assign ptr       = r_ptr;
    assign count     = r_count;
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Directed testbench for ring_buffer_ctrl: a DEPTH=3 instance for the main scenarios and a DEPTH=5 instance for wrap checks.
module tb_ring_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d_in, d_in5;
    logic       ld, clr, inc, dec;
    logic       ld5, clr5, inc5, dec5;

    logic [3:0] data_out, data_out5;
    logic       out_valid, out_valid5;
    logic [1:0] ptr;
    logic [2:0] ptr5;
    logic [1:0] count;
    logic [2:0] count5;
    logic       full, empty, ovf;
    logic       full5, empty5, ovf5;

    int n_tests = 0;
    int n_fail  = 0;
    int lat_inc = 3;
    int lat_dec = 3;
    int lat_ld  = 11;

    always #5 clk = ~clk;

    ring_buffer_ctrl #(.WIDTH(4), .DEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(d_in), .ld(ld), .clr(clr), .inc(inc), .dec(dec),
        .data_out(data_out), .out_valid(out_valid), .ptr(ptr), .count(count),
        .full(full), .empty(empty), .ovf(ovf)
    );

    ring_buffer_ctrl #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .data_in(d_in5), .ld(ld5), .clr(clr5), .inc(inc5), .dec(dec5),
        .data_out(data_out5), .out_valid(out_valid5), .ptr(ptr5), .count(count5),
        .full(full5), .empty(empty5), .ovf(ovf5)
    );

    // Raise the requested raw inputs so that all resulting pulses land in the same cycle,
    // then return one sample point after the state update.
    task automatic apply(input bit tgt5, input bit c, input bit l, input bit i, input bit d,
                         input logic [3:0] data);
        int len;
        len = (c || l) ? lat_ld : lat_inc;
        for (int k = 0; k < len; k++) begin
            if (k == 0) begin
                if (tgt5) begin clr5 = c; ld5 = l; d_in5 = data; end
                else      begin clr  = c; ld  = l; d_in  = data; end
            end
            if (k == len - lat_inc) begin
                if (tgt5) begin inc5 = i; dec5 = d; end
                else      begin inc  = i; dec  = d; end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_all();
        ld = 0; clr = 0; inc = 0; dec = 0;
        ld5 = 0; clr5 = 0; inc5 = 0; dec5 = 0;
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        d_in = 0; d_in5 = 0;
        ld = 0; clr = 0; inc = 0; dec = 0;
        ld5 = 0; clr5 = 0; inc5 = 0; dec5 = 0;
        #23 rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (ptr !== 2'd0)      begin n_fail++; $display("FAIL rst_ptr: got %0d want 0", ptr); end
        n_tests++; if (count !== 2'd0)    begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_tests++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", data_out); end
        n_tests++; if (out_valid !== 1'b0 || ovf !== 1'b0 || full !== 1'b0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL rst_flags: got v%0b o%0b f%0b e%0b want v0 o0 f0 e1", out_valid, ovf, full, empty); end
        n_tests++; if (ptr5 !== 3'd0 || empty5 !== 1'b1) begin n_fail++; $display("FAIL rst_d5: got ptr %0d empty %0b want 0 1", ptr5, empty5); end
    endtask

    task automatic test_latency();
        bit found;
        found = 0;
        inc = 1;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(posedge clk); #1;
            if (ptr !== 2'd0) begin lat_inc = c; found = 1; end
        end
        n_tests++; if (!found || ptr !== 2'd1) begin n_fail++; $display("FAIL lat_inc: got ptr %0d want 1 within 40 cycles", ptr); end
        if (!found) lat_inc = 3;
        release_all();
        found = 0;
        dec = 1;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(posedge clk); #1;
            if (ptr !== 2'd1) begin lat_dec = c; found = 1; end
        end
        n_tests++; if (!found || ptr !== 2'd0) begin n_fail++; $display("FAIL lat_dec: got ptr %0d want 0 within 40 cycles", ptr); end
        n_tests++; if (lat_dec != lat_inc) begin n_fail++; $display("FAIL lat_match: got dec %0d want inc %0d", lat_dec, lat_inc); end
        release_all();
        found = 0;
        ld = 1; d_in = 4'hF;
        for (int c = 1; c <= 60 && !found; c++) begin
            @(posedge clk); #1;
            if (count !== 2'd0) begin lat_ld = c; found = 1; end
        end
        n_tests++; if (!found || count !== 2'd1 || ptr !== 2'd1) begin n_fail++; $display("FAIL lat_ld: got count %0d ptr %0d want 1 1", count, ptr); end
        n_tests++; if (lat_ld <= lat_inc) begin n_fail++; $display("FAIL lat_ld_window: got %0d want > %0d", lat_ld, lat_inc); end
        if (!found || lat_ld <= lat_inc) lat_ld = 11;
        release_all();
        apply(0, 1, 0, 0, 0, 4'h0);
        n_tests++; if (count !== 2'd0 || ptr !== 2'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL clr_basic: got count %0d ptr %0d empty %0b want 0 0 1", count, ptr, empty); end
        release_all();
    endtask

    task automatic test_load_sequence();
        apply(0, 0, 1, 0, 0, 4'h5);
        n_tests++; if (ptr !== 2'd1 || count !== 2'd1) begin n_fail++; $display("FAIL ld1: got ptr %0d count %0d want 1 1", ptr, count); end
        release_all();
        apply(0, 0, 1, 0, 0, 4'hA);
        n_tests++; if (ptr !== 2'd2 || count !== 2'd2) begin n_fail++; $display("FAIL ld2: got ptr %0d count %0d want 2 2", ptr, count); end
        n_tests++; if (full !== 1'b0 || empty !== 1'b0) begin n_fail++; $display("FAIL ld2_flags: got f%0b e%0b want f0 e0", full, empty); end
        release_all();
        apply(0, 0, 1, 0, 0, 4'h3);
        n_tests++; if (ptr !== 2'd0 || count !== 2'd3) begin n_fail++; $display("FAIL ld3: got ptr %0d count %0d want 0 3", ptr, count); end
        n_tests++; if (full !== 1'b1 || data_out !== 4'h5 || out_valid !== 1'b1 || ovf !== 1'b0)
            begin n_fail++; $display("FAIL ld3_out: got f%0b d%0h v%0b o%0b want f1 d5 v1 o0", full, data_out, out_valid, ovf); end
        release_all();
    endtask

    task automatic test_overwrite();
        apply(0, 0, 1, 0, 0, 4'hC);
        n_tests++; if (ptr !== 2'd1 || count !== 2'd3 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovw: got ptr %0d count %0d ovf %0b want 1 3 1", ptr, count, ovf); end
        n_tests++; if (data_out !== 4'hA || full !== 1'b1) begin n_fail++; $display("FAIL ovw_out: got d%0h f%0b want dA f1", data_out, full); end
        release_all();
        apply(0, 0, 0, 0, 1, 4'h0);
        n_tests++; if (ptr !== 2'd0 || data_out !== 4'hC || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovw_dec1: got ptr %0d d%0h v%0b want 0 C 1", ptr, data_out, out_valid); end
        release_all();
        apply(0, 0, 0, 0, 1, 4'h0);
        n_tests++; if (ptr !== 2'd2 || data_out !== 4'h3) begin n_fail++; $display("FAIL ovw_dec2: got ptr %0d d%0h want 2 3", ptr, data_out); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
        release_all();
    endtask

    task automatic test_depth5();
        apply(1, 0, 0, 0, 1, 4'h0);
        n_tests++; if (ptr5 !== 3'd4 || out_valid5 !== 1'b0) begin n_fail++; $display("FAIL d5_dec: got ptr %0d v%0b want 4 0", ptr5, out_valid5); end
        release_all();
        for (int s = 0; s < 5; s++) begin
            apply(1, 0, 0, 1, 0, 4'h0);
            n_tests++; if (ptr5 !== 3'(s) || out_valid5 !== 1'b0 || empty5 !== 1'b1)
                begin n_fail++; $display("FAIL d5_inc%0d: got ptr %0d v%0b e%0b want %0d 0 1", s, ptr5, out_valid5, empty5, s); end
            release_all();
        end
        apply(1, 0, 0, 0, 1, 4'h0);
        n_tests++; if (ptr5 !== 3'd3) begin n_fail++; $display("FAIL d5_dec_mid: got ptr %0d want 3", ptr5); end
        release_all();
    endtask

    task automatic test_simultaneous();
        apply(0, 0, 0, 1, 1, 4'h0);
        n_tests++; if (ptr !== 2'd2) begin n_fail++; $display("FAIL incdec: got ptr %0d want 2", ptr); end
        release_all();
        apply(0, 0, 1, 1, 0, 4'h9);
        n_tests++; if (ptr !== 2'd0 || count !== 2'd3 || data_out !== 4'hC) begin n_fail++; $display("FAIL ldinc: got ptr %0d count %0d d%0h want 0 3 C", ptr, count, data_out); end
        release_all();
        apply(0, 0, 0, 0, 1, 4'h0);
        n_tests++; if (ptr !== 2'd2 || data_out !== 4'h9) begin n_fail++; $display("FAIL ldinc_data: got ptr %0d d%0h want 2 9", ptr, data_out); end
        release_all();
        apply(0, 1, 1, 0, 0, 4'h7);
        n_tests++; if (ptr !== 2'd0 || count !== 2'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL clrld: got ptr %0d count %0d ovf %0b want 0 0 0", ptr, count, ovf); end
        n_tests++; if (data_out !== 4'h0 || out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0)
            begin n_fail++; $display("FAIL clrld_out: got d%0h v%0b e%0b f%0b want 0 0 1 0", data_out, out_valid, empty, full); end
        release_all();
        apply(0, 0, 0, 1, 0, 4'h0);
        n_tests++; if (ptr !== 2'd1 || data_out !== 4'h0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_mem: got ptr %0d d%0h v%0b want 1 0 0", ptr, data_out, out_valid); end
        release_all();
    endtask

    task automatic test_bounce();
        d_in = 4'h6;
        ld = 1;
        repeat (3) @(posedge clk);
        ld = 0;
        repeat (30) @(posedge clk);
        #1;
        n_tests++; if (count !== 2'd0 || ptr !== 2'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bounce: got count %0d ptr %0d v%0b want 0 1 0", count, ptr, out_valid); end
        ld = 1;
        repeat (1000) @(posedge clk);
        #1;
        n_tests++; if (count !== 2'd1 || ptr !== 2'd2 || ovf !== 1'b0) begin n_fail++; $display("FAIL held: got count %0d ptr %0d ovf %0b want 1 2 0", count, ptr, ovf); end
        release_all();
        apply(0, 0, 0, 0, 1, 4'h0);
        n_tests++; if (ptr !== 2'd1 || data_out !== 4'h6 || out_valid !== 1'b1) begin n_fail++; $display("FAIL held_data: got ptr %0d d%0h v%0b want 1 6 1", ptr, data_out, out_valid); end
        release_all();
    endtask

    task automatic test_async_reset();
        apply(0, 1, 0, 0, 0, 4'h0); release_all();
        apply(0, 0, 1, 0, 0, 4'h1); release_all();
        apply(0, 0, 1, 0, 0, 4'h2); release_all();
        apply(0, 0, 0, 0, 1, 4'h0); release_all();
        apply(0, 0, 0, 0, 1, 4'h0); release_all();
        apply(0, 0, 1, 0, 0, 4'h7);
        n_tests++; if (count !== 2'd2 || ovf !== 1'b1 || ptr !== 2'd1) begin n_fail++; $display("FAIL pre_rst: got count %0d ovf %0b ptr %0d want 2 1 1", count, ovf, ptr); end
        release_all();
        ld = 1; d_in = 4'hE;
        @(posedge clk);
        #4 rst_n = 0;
        #1;
        n_tests++; if (ptr !== 2'd0 || count !== 2'd0 || ovf !== 1'b0 || data_out !== 4'h0)
            begin n_fail++; $display("FAIL async_rst: got ptr %0d count %0d ovf %0b d%0h want 0 0 0 0", ptr, count, ovf, data_out); end
        n_tests++; if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0)
            begin n_fail++; $display("FAIL async_rst_flags: got v%0b e%0b f%0b want 0 1 0", out_valid, empty, full); end
        #2 rst_n = 1;
        repeat (40) @(posedge clk);
        #1;
        n_tests++; if (count !== 2'd0 || ptr !== 2'd0) begin n_fail++; $display("FAIL held_rst: got count %0d ptr %0d want 0 0", count, ptr); end
        release_all();
        apply(0, 0, 1, 0, 0, 4'h4);
        n_tests++; if (count !== 2'd1 || ptr !== 2'd1) begin n_fail++; $display("FAIL repress: got count %0d ptr %0d want 1 1", count, ptr); end
        release_all();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_load_sequence();
        test_overwrite();
        test_depth5();
        test_simultaneous();
        test_bounce();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
